// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared Kyber constants, sampler state type and candidate test
package kyber_pkg;

    localparam int KYBER_Q   = 3329;
    localparam int N_COEFF   = 256;
    localparam int COEFF_W   = 12;
    localparam int XOF_BITS  = 5376;
    localparam int N_TRIPLES = XOF_BITS / 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FIN    = 2'd3
    } sample_state_t;

    // A 12-bit candidate survives rejection only if it is already reduced mod q
    function automatic logic cand_ok(input logic [COEFF_W-1:0] d);
        return d < 12'(KYBER_Q);
    endfunction

endpackage

// File: rtl/coeff_fifo2.sv
// rtl/coeff_fifo2.sv - two-entry coefficient FIFO taking up to two pushes and one pop per cycle
module coeff_fifo2
    import kyber_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         i_push_n,
    input  logic [COEFF_W-1:0] i_push_a,
    input  logic [COEFF_W-1:0] i_push_b,
    input  logic               i_pop,
    output logic [COEFF_W-1:0] o_head,
    output logic               o_empty,
    output logic [1:0]         o_free
);

    logic [COEFF_W-1:0] r_mem0;
    logic [COEFF_W-1:0] r_mem1;
    logic [1:0]         r_cnt;

    logic [COEFF_W-1:0] w_pop_m0;
    logic [1:0]         w_pop_cnt;
    logic [COEFF_W-1:0] w_nxt_m0;
    logic [COEFF_W-1:0] w_nxt_m1;
    logic [1:0]         w_nxt_cnt;

    // Pop first (shift entry 1 to the head), then append pushes behind what remains
    always_comb begin
        w_pop_m0  = r_mem0;
        w_pop_cnt = r_cnt;
        if (i_pop && (r_cnt != 2'd0)) begin
            w_pop_m0  = r_mem1;
            w_pop_cnt = r_cnt - 2'd1;
        end
        w_nxt_m0  = w_pop_m0;
        w_nxt_m1  = r_mem1;
        w_nxt_cnt = w_pop_cnt + i_push_n;
        if (i_push_n == 2'd1) begin
            if (w_pop_cnt == 2'd0) begin
                w_nxt_m0 = i_push_a;
            end else begin
                w_nxt_m1 = i_push_a;
            end
        end else if (i_push_n == 2'd2) begin
            w_nxt_m0 = i_push_a;
            w_nxt_m1 = i_push_b;
        end
    end

    // Storage and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem0 <= '0;
            r_mem1 <= '0;
            r_cnt  <= 2'd0;
        end else begin
            r_mem0 <= w_nxt_m0;
            r_mem1 <= w_nxt_m1;
            r_cnt  <= w_nxt_cnt;
        end
    end

    assign o_head  = r_mem0;
    assign o_empty = (r_cnt == 2'd0);
    assign o_free  = 2'd2 - r_cnt;

endmodule

// File: rtl/sample_ntt_reject.sv
// rtl/sample_ntt_reject.sv - Kyber SampleNTT rejection sampler streaming 256 coefficients from an XOF block
module sample_ntt_reject
    import kyber_pkg::*;
#(
    parameter int IN_BITS = XOF_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IN_BITS-1:0] in_bits,
    output logic [11:0]        coeff_out,
    output logic [7:0]         coeff_idx,
    output logic               coeff_valid,
    input  logic               coeff_ready,
    output logic               busy,
    output logic               done,
    output logic               short_out
);

    localparam int N_TRIP = IN_BITS / 24;
    localparam int OFF_W  = $clog2(IN_BITS);
    localparam logic [8:0] N9 = 9'(N_COEFF);

    sample_state_t      r_state;
    logic [IN_BITS-1:0] r_buf;
    logic [7:0]         r_trip_idx;
    logic [8:0]         r_acc_cnt;
    logic [8:0]         r_emit_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_short;

    logic [7:0]         w_sel;
    logic [OFF_W-1:0]   w_off;
    logic [23:0]        w_triple;
    logic [11:0]        w_d1;
    logic [11:0]        w_d2;
    logic [1:0]         w_free;
    logic [2:0]         w_free_eff;
    logic               w_empty;
    logic               w_pop;
    logic               w_go;
    logic               w_acc1;
    logic               w_acc2;
    logic [8:0]         w_acc_next;
    logic [1:0]         w_push_n;
    logic [11:0]        w_push_a;

    // Triple mux and the two rejection comparators; a pop in the same cycle frees a slot
    always_comb begin
        w_sel      = (r_trip_idx < 8'(N_TRIP)) ? r_trip_idx : 8'd0;
        w_off      = OFF_W'(w_sel) * OFF_W'(24);
        w_triple   = r_buf[w_off +: 24];
        w_d1       = w_triple[11:0];
        w_d2       = w_triple[23:12];
        w_pop      = !w_empty && coeff_ready;
        w_free_eff = {1'b0, w_free} + {2'b00, w_pop};
        w_go       = (r_state == ST_SAMPLE) && (w_free_eff >= 3'd2);
        w_acc1     = w_go && cand_ok(w_d1) && (r_acc_cnt < N9);
        w_acc2     = w_go && cand_ok(w_d2) && ((r_acc_cnt + 9'(w_acc1)) < N9);
        w_acc_next = r_acc_cnt + 9'(w_acc1) + 9'(w_acc2);
        w_push_n   = {w_acc1 & w_acc2, w_acc1 ^ w_acc2};
        w_push_a   = w_acc1 ? w_d1 : w_d2;
    end

    coeff_fifo2 u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_push_n (w_push_n),
        .i_push_a (w_push_a),
        .i_push_b (w_d2),
        .i_pop    (w_pop),
        .o_head   (coeff_out),
        .o_empty  (w_empty),
        .o_free   (w_free)
    );

    // Sampler FSM with capture buffer, triple/accept/emit counters and status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_buf      <= '0;
            r_trip_idx <= 8'd0;
            r_acc_cnt  <= 9'd0;
            r_emit_cnt <= 9'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_short    <= 1'b0;
        end else begin
            if (w_pop) begin
                r_emit_cnt <= r_emit_cnt + 9'd1;
            end
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    if (start) begin
                        r_buf      <= in_bits;
                        r_trip_idx <= 8'd0;
                        r_acc_cnt  <= 9'd0;
                        r_emit_cnt <= 9'd0;
                        r_done     <= 1'b0;
                        r_short    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (w_go) begin
                        r_trip_idx <= r_trip_idx + 8'd1;
                        r_acc_cnt  <= w_acc_next;
                        if ((w_acc_next == N9) || (r_trip_idx == 8'(N_TRIP - 1))) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_empty && (r_emit_cnt == r_acc_cnt)) begin
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_short <= (r_acc_cnt < N9);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign coeff_valid = !w_empty;
    assign coeff_idx   = r_emit_cnt[7:0];
    assign busy        = r_busy;
    assign done        = r_done;
    assign short_out   = r_short;

endmodule

// File: tb/tb_sample_ntt_reject.sv
// tb/tb_sample_ntt_reject.sv - self-checking bench for sample_ntt_reject against a byte-level SampleNTT model
module tb_sample_ntt_reject;

    logic          clk;
    logic          rst;
    logic          start;
    logic [5375:0] in_bits;
    logic [11:0]   coeff_out;
    logic [7:0]    coeff_idx;
    logic          coeff_valid;
    logic          coeff_ready;
    logic          busy;
    logic          done;
    logic          short_out;

    int n_checks;
    int n_fail;

    sample_ntt_reject dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_bits     (in_bits),
        .coeff_out   (coeff_out),
        .coeff_idx   (coeff_idx),
        .coeff_valid (coeff_valid),
        .coeff_ready (coeff_ready),
        .busy        (busy),
        .done        (done),
        .short_out   (short_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: walk bytes three at a time, build two 12-bit values, keep those < 3329 up to 256
    task automatic model(input logic [5375:0] blk, output int q[$]);
        int b0, b1, b2, d1, d2;
        q = {};
        for (int t = 0; t < 224; t++) begin
            b0 = int'(blk[24*t +: 8]);
            b1 = int'(blk[24*t+8 +: 8]);
            b2 = int'(blk[24*t+16 +: 8]);
            d1 = b0 + 256 * (b1 % 16);
            d2 = (b1 / 16) + 16 * b2;
            if (d1 < 3329 && q.size() < 256) q.push_back(d1);
            if (d2 < 3329 && q.size() < 256) q.push_back(d2);
        end
    endtask

    task automatic run_case(input string name, input logic [5375:0] blk, input int rdy_pct,
                            input bit inj, input int exp_fin, output int first_val);
        int exp_q[$];
        int n_got, cyc, nvalid;
        bit fin;
        logic pv, pr;
        logic [11:0] po;
        logic [7:0] pi;
        model(blk, exp_q);
        first_val = -1;
        in_bits = blk;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        chk({name, "_busy_start"}, 32'(busy), 32'd1);
        chk({name, "_done_cleared"}, 32'(done), 32'd0);
        n_got = 0; nvalid = 0; fin = 1'b0; pv = 1'b0; pr = 1'b0; po = '0; pi = '0;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            if (pv && !pr) begin
                chk({name, "_hold_valid"}, 32'(coeff_valid), 32'd1);
                chk({name, "_hold_out"}, 32'(coeff_out), 32'(po));
                chk({name, "_hold_idx"}, 32'(coeff_idx), 32'(pi));
            end
            coeff_ready = ($urandom_range(99) < rdy_pct);
            if (inj && cyc == 20) begin
                start = 1'b1;
                in_bits = ~blk;
            end else begin
                start = 1'b0;
            end
            if (coeff_valid) nvalid++;
            if (coeff_valid && coeff_ready) begin
                if (n_got < exp_q.size()) begin
                    chk({name, "_val"}, 32'(coeff_out), 32'(exp_q[n_got]));
                    chk({name, "_idx"}, 32'(coeff_idx), 32'(n_got % 256));
                end else begin
                    chk({name, "_extra_coeff"}, 32'(n_got), 32'(exp_q.size()));
                end
                if (n_got == 0) first_val = int'(coeff_out);
                n_got++;
            end
            pv = coeff_valid; pr = coeff_ready; po = coeff_out; pi = coeff_idx;
            @(posedge clk);
            cyc++;
            #1;
            if (done) fin = 1'b1;
        end
        start = 1'b0;
        chk({name, "_finished"}, 32'(fin), 32'd1);
        chk({name, "_count"}, 32'(n_got), 32'(exp_q.size()));
        chk({name, "_short"}, 32'(short_out), 32'(exp_q.size() < 256));
        chk({name, "_busy_end"}, 32'(busy), 32'd0);
        chk({name, "_valid_end"}, 32'(coeff_valid), 32'd0);
        if (exp_fin >= 0) chk({name, "_fin_cycles"}, 32'(cyc), 32'(exp_fin));
        if (exp_q.size() == 0) chk({name, "_no_valid"}, 32'(nvalid), 32'd0);
    endtask

    function automatic logic [5375:0] rand_blk(input int sparse_pct);
        logic [5375:0] b;
        for (int t = 0; t < 224; t++) begin
            if ($urandom_range(99) < sparse_pct) b[24*t +: 24] = 24'hFFFFFF;
            else b[24*t +: 24] = 24'($urandom);
        end
        return b;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(coeff_valid), 32'd0);
        chk({tag, "_out"}, 32'(coeff_out), 32'd0);
        chk({tag, "_idx"}, 32'(coeff_idx), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_short"}, 32'(short_out), 32'd0);
    endtask

    initial begin
        logic [5375:0] blk;
        int fv;
        n_checks = 0;
        n_fail = 0;
        rst = 1'b0;
        start = 1'b0;
        in_bits = '0;
        coeff_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        blk = '0;
        run_case("zeros", blk, 100, 1'b0, -1, fv);
        chk("zeros_first", 32'(fv), 32'd0);

        blk = '1;
        run_case("ones", blk, 100, 1'b0, 226, fv);

        blk = '0;
        blk[23:0] = 24'hD01D00;
        run_case("triple0", blk, 100, 1'b0, -1, fv);
        chk("triple0_first", 32'(fv), 32'd3328);

        for (int k = 0; k < 3; k++) begin
            run_case("rand", rand_blk(0), 50, 1'b0, -1, fv);
        end
        run_case("sparse", rand_blk(75), 50, 1'b0, -1, fv);

        // Abort a run with reset, then confirm a clean restart
        blk = rand_blk(0);
        in_bits = blk;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done), 32'd0);
        run_case("after_rst", rand_blk(0), 50, 1'b0, -1, fv);

        run_case("start_inject", rand_blk(0), 50, 1'b1, -1, fv);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
